// File: rtl/cam_pkg.sv
// cam_pkg: shared encodings for the CAM allocation controller.
//   op_e     : request operation (insert / remove)
//   status_e : response status (OK / FULL / NOT_FOUND / DUPLICATE)
//   state_e  : controller FSM states
package cam_pkg;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_REMOVE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK        = 2'd0,
        RSP_FULL      = 2'd1,
        RSP_NOT_FOUND = 2'd2,
        RSP_DUPLICATE = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_MATCH  = 3'd3,
        S_WRITE  = 3'd4,
        S_WAIT   = 3'd5,
        S_RESP   = 3'd6
    } state_e;

endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: reports the index of one set bit of input_unencoded.
//   WIDTH        : number of request bits
//   LSB_PRIORITY : "HIGH" -> lowest set index wins, otherwise highest wins
// Ports:
//   input_unencoded  in  WIDTH   request bits
//   output_valid     out 1       at least one bit set
//   output_encoded   out log2    index of the winning bit (0 when none set)
module priority_encoder #(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "LOW"
) (
    input  logic [WIDTH-1:0]                              input_unencoded,
    output logic                                          output_valid,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]  output_encoded
);

    localparam int ENC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (LSB_PRIORITY == "HIGH") begin : g_lsb_high
            // Scan downward so the lowest set bit is the last one written.
            always_comb begin
                output_valid   = 1'b0;
                output_encoded = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (input_unencoded[i]) begin
                        output_valid   = 1'b1;
                        output_encoded = ENC_W'(i);
                    end
                end
            end
        end else begin : g_msb_high
            always_comb begin
                output_valid   = 1'b0;
                output_encoded = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (input_unencoded[i]) begin
                        output_valid   = 1'b1;
                        output_encoded = ENC_W'(i);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cam_alloc_ctrl.sv
// cam_alloc_ctrl: allocates and frees entries of an attached CAM.
// Inserts pick the lowest free entry; removes look the key up and delete
// the matching entry. One request is in flight at a time.
//
// Optional feature macro: CAM_ALLOC_DUP_CHECK_EN
//   defined   : inserts are looked up first; an existing key returns DUPLICATE
//   undefined : inserts go straight to free-slot choice (no lookup)
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready/req_op/req_key   request handshake (op 0 insert, 1 remove)
//   resp_valid/resp_addr/resp_status     one-cycle response
//   cam_write_*                     CAM write side (busy is an input)
//   cam_compare_data/cam_match/cam_match_addr   CAM search side (1-cycle latency)
//   occupancy, full                 allocated-entry count and full flag
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_INIT   | wait for the CAM to finish its own reset clear
// S_IDLE   | ready for a request
// S_LOOKUP | key on compare bus, CAM match register loading
// S_MATCH  | sample match result, decide target / early response
// S_WRITE  | issue single write-enable pulse once CAM not busy
// S_WAIT   | wait for CAM write to complete
// S_RESP   | one-cycle response pulse
module cam_alloc_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_key,

    output logic                  resp_valid,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_status,

    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,

    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,

    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  full
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] OCC_ONE   = (ADDR_WIDTH + 1)'(1);

    state_e                  state_q,  state_d;
    op_e                     op_q,     op_d;
    logic [DATA_WIDTH-1:0]   key_q,    key_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    status_e                 status_q, status_d;
    logic [DEPTH-1:0]        bitmap_q, bitmap_d;
    logic [ADDR_WIDTH:0]     occ_q,    occ_d;
    logic                    wait_first_q, wait_first_d;

    logic                    free_valid;
    logic [ADDR_WIDTH-1:0]   free_idx;

    // Allocation decision shared by the direct-insert and post-lookup paths.
    state_e                  alloc_state;
    logic [ADDR_WIDTH-1:0]   alloc_addr;
    status_e                 alloc_status;

    priority_encoder #(
        .WIDTH        (DEPTH),
        .LSB_PRIORITY ("HIGH")
    ) u_free_enc (
        .input_unencoded (~bitmap_q),
        .output_valid    (free_valid),
        .output_encoded  (free_idx)
    );

    assign full             = (occ_q == DEPTH_CNT);
    assign occupancy        = occ_q;
    assign resp_addr        = addr_q;
    assign resp_status      = status_q;
    assign cam_write_addr   = addr_q;
    assign cam_write_data   = key_q;
    assign cam_write_delete = (op_q == OP_REMOVE);
    assign cam_compare_data = key_q;

    always_comb begin
        alloc_state  = S_WRITE;
        alloc_addr   = free_idx;
        alloc_status = RSP_OK;
        if (full || !free_valid) begin
            alloc_state  = S_RESP;
            alloc_addr   = '0;
            alloc_status = RSP_FULL;
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        key_d            = key_q;
        addr_d           = addr_q;
        status_d         = status_q;
        bitmap_d         = bitmap_q;
        occ_d            = occ_q;
        wait_first_d     = wait_first_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        cam_write_enable = 1'b0;

        case (state_q)
            S_INIT: begin
                if (!cam_write_busy) state_d = S_IDLE;
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d  = op_e'(req_op);
                    key_d = req_key;
`ifdef CAM_ALLOC_DUP_CHECK_EN
                    state_d = S_LOOKUP;
`else
                    if (op_e'(req_op) == OP_REMOVE) begin
                        state_d = S_LOOKUP;
                    end else begin
                        state_d  = alloc_state;
                        addr_d   = alloc_addr;
                        status_d = alloc_status;
                    end
`endif
                end
            end
            S_LOOKUP: begin
                state_d = S_MATCH;
            end
            S_MATCH: begin
                if (op_q == OP_REMOVE) begin
                    if (cam_match) begin
                        state_d  = S_WRITE;
                        addr_d   = cam_match_addr;
                        status_d = RSP_OK;
                    end else begin
                        state_d  = S_RESP;
                        addr_d   = '0;
                        status_d = RSP_NOT_FOUND;
                    end
                end else begin
`ifdef CAM_ALLOC_DUP_CHECK_EN
                    if (cam_match) begin
                        state_d  = S_RESP;
                        addr_d   = cam_match_addr;
                        status_d = RSP_DUPLICATE;
                    end else begin
                        state_d  = alloc_state;
                        addr_d   = alloc_addr;
                        status_d = alloc_status;
                    end
`else
                    state_d  = alloc_state;
                    addr_d   = alloc_addr;
                    status_d = alloc_status;
`endif
                end
            end
            S_WRITE: begin
                if (!cam_write_busy) begin
                    cam_write_enable = 1'b1;
                    wait_first_d     = 1'b1;
                    state_d          = S_WAIT;
                    // Guards keep the count consistent with the bitmap even if
                    // the CAM ever reports a match on an entry we think is free.
                    if (op_q == OP_INSERT) begin
                        if (!bitmap_q[addr_q]) occ_d = occ_q + OCC_ONE;
                        bitmap_d[addr_q] = 1'b1;
                    end else begin
                        if (bitmap_q[addr_q]) occ_d = occ_q - OCC_ONE;
                        bitmap_d[addr_q] = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                // The CAM raises busy one cycle after the enable, so the first
                // WAIT cycle cannot trust a low busy.
                wait_first_d = 1'b0;
                if (!wait_first_q && !cam_write_busy) state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            op_q         <= OP_INSERT;
            key_q        <= '0;
            addr_q       <= '0;
            status_q     <= RSP_OK;
            bitmap_q     <= '0;
            occ_q        <= '0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            key_q        <= key_d;
            addr_q       <= addr_d;
            status_q     <= status_d;
            bitmap_q     <= bitmap_d;
            occ_q        <= occ_d;
            wait_first_q <= wait_first_d;
        end
    end

endmodule

// File: doc/cam_alloc_ctrl.md
CAM_ALLOC_CTRL -- requirements
Module: cam_alloc_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, key width; equals the attached CAM search width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, log2 of CAM entries; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  in  1  sole clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_op in 1 (0 insert, 1 remove), req_key in DATA_WIDTH.
REQ-006 SHALL have ports resp_valid out 1, resp_addr out ADDR_WIDTH, resp_status out 2 (0 OK, 1 FULL, 2 NOT_FOUND, 3 DUPLICATE).
REQ-007 SHALL have CAM write-side ports cam_write_addr out ADDR_WIDTH, cam_write_data out DATA_WIDTH, cam_write_delete out 1, cam_write_enable out 1, cam_write_busy in 1.
REQ-008 SHALL have CAM search-side ports cam_compare_data out DATA_WIDTH, cam_match in 1, cam_match_addr in ADDR_WIDTH.
REQ-009 SHALL have status ports occupancy out ADDR_WIDTH+1 and full out 1.

Function
REQ-010 SHALL implement states INIT, IDLE, LOOKUP, MATCH, WRITE, WAIT, RESP.
REQ-011 INIT: req_ready low; SHALL go to IDLE on the first cycle cam_write_busy is low.
REQ-012 IDLE: req_ready high; on req_valid&req_ready SHALL latch op/key, drive cam_compare_data=key, go to LOOKUP.
REQ-013 cam_compare_data SHALL hold the latched key from LOOKUP through RESP.
REQ-014 LOOKUP SHALL last one cycle to cover the CAM's one-cycle registered match latency; MATCH samples cam_match/cam_match_addr.
REQ-015 Insert, no match, not full: SHALL select the lowest-index free entry from the valid bitmap and go to WRITE.
REQ-016 Insert while full: SHALL return FULL with resp_addr=0, no CAM write.
REQ-017 Remove, match: SHALL target cam_match_addr with cam_write_delete=1; remove, no match: SHALL return NOT_FOUND with resp_addr=0.
REQ-018 WRITE: SHALL assert cam_write_enable for exactly one cycle, only when cam_write_busy is low, then go to WAIT.
REQ-019 WAIT: SHALL ignore busy in the first cycle, then go to RESP when cam_write_busy is low.
REQ-020 Valid bitmap and occupancy SHALL update on the WRITE enable cycle (+1 insert, -1 remove); full = occupancy==DEPTH.
REQ-021 RESP: resp_valid SHALL pulse for one cycle with status and final address; OK returns the written/deleted address; then go to IDLE.
REQ-022 At most one request SHALL be in flight; req_ready SHALL be low outside IDLE.
REQ-023 Back-to-back requests SHALL see CAM contents including the previous write; min request spacing is the 7-cycle turnaround plus the CAM write time.

Reset
REQ-024 On rst SHALL enter INIT, clear bitmap, occupancy=0, full=0, resp_valid=0, cam_write_enable=0, req_ready=0, resp_addr=0, resp_status=0, cam outputs 0.
REQ-025 rst mid-operation SHALL abort silently, with no response; the CAM shares rst, so contents stay consistent.

Configuration
REQ-026 With CAM_ALLOC_DUP_CHECK_EN defined, an insert hitting an existing key SHALL return DUPLICATE with the matched address and no write.
REQ-027 Without CAM_ALLOC_DUP_CHECK_EN, an insert SHALL skip LOOKUP/MATCH, go directly to the free-slot choice, and never return DUPLICATE.

Structure
REQ-028 Package cam_pkg SHALL hold the op encoding, status encoding and state encoding.
REQ-029 Free-slot selection SHALL instantiate the existing priority_encoder (LSB_PRIORITY "HIGH") on the inverted bitmap.

Verification (DATA_WIDTH=64, ADDR_WIDTH=5, real CAM attached)
REQ-030 Reset then insert key 0x1234 -> resp OK addr 0, occupancy 1; compare 0x1234 yields cam_match at addr 0.
REQ-031 Insert 32 distinct keys, then a 33rd -> 33rd returns FULL, full=1, no cam_write_enable pulse.
REQ-032 Insert keys A,B,C (addrs 0,1,2), remove B -> OK addr 1; next insert D -> OK addr 1.
REQ-033 Remove absent key 0xDEAD -> NOT_FOUND, occupancy unchanged.
REQ-034 DUP_CHECK_EN: insert 0x55 twice -> second returns DUPLICATE addr 0, occupancy 1; macro undefined -> OK addr 1.
REQ-035 Assert rst during WAIT of an insert -> no resp_valid, occupancy 0, req_ready rises only after CAM INIT completes.
